mem_stage_hs: RTL and testbench

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

---
 rtl/mem_stage_hs_if.sv | 23 ++
 rtl/mem_stage_hs.sv | 147 ++++++++++++++
 tb/tb_mem_stage_hs.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// Memory-side bus of the MEM stage: request, address, byte enables and store data out;
// read data and completion ack back from the memory.
interface mem_stage_hs_if #(
  parameter int WIDTH = 32
);
  logic               memReq;
  logic               memWe;
  logic [WIDTH-1:0]   memAddr;
  logic [WIDTH-1:0]   memWData;
  logic [WIDTH/8-1:0] memBE;
  logic [WIDTH-1:0]   memRData;
  logic               memAck;

  modport master (
    output memReq, memWe, memAddr, memWData, memBE,
    input  memRData, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWData, memBE,
    output memRData, memAck
  );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: issues loads/stores, lane-aligns data, registers M->W (latency 1, 0 extra on same-cycle ack).
// Backpressure: stallM holds upstream while a request waits for memAck; aborts after TIMEOUT-1 stalled cycles.
module mem_stage_hs #(
  parameter int WIDTH   = 32,
  parameter int REGW    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             validM,
  input  logic             memReadM,
  input  logic             memWriteM,
  input  logic [1:0]       sizeM,
  input  logic             signedM,
  input  logic             plusOneM,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] writeDataM,
  input  logic [REGW-1:0]  WA3M,
  input  logic             memToRegM,
  input  logic             regWriteM,
  input  logic             flushM,
  mem_stage_hs_if.master   mem,
  output logic             stallM,
  output logic             validW,
  output logic             memToRegW,
  output logic             regWriteW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] readDataW,
  output logic [REGW-1:0]  WA3W,
  output logic [1:0]       errFlags
);
  localparam int NB = WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_validW, r_memToRegW, r_regWriteW;
  logic [WIDTH-1:0] r_ALUResultW, r_readDataW;
  logic [REGW-1:0]  r_WA3W;
  logic [1:0]       r_err;

  logic             w_memop, w_is_byte, w_is_half, w_is_word, w_mis;
  logic             w_req, w_ack, w_abort, w_stall;
  logic [LB-1:0]    w_lane, w_hlane;
  logic [WIDTH-1:0] w_d, w_wdat, w_ld;
  logic [NB-1:0]    w_be;
  logic [7:0]       w_rb;
  logic [15:0]      w_rh;

  assign w_memop   = validM & (memReadM | memWriteM) & ~flushM;
  assign w_is_byte = (sizeM == 2'b10);
  assign w_is_half = (sizeM == 2'b01);
  assign w_is_word = ~w_is_byte & ~w_is_half;
  assign w_mis     = w_memop & ((w_is_half & ALUResultM[0]) |
                                (w_is_word & (ALUResultM[1:0] != 2'b00)));
  assign w_req     = w_memop & ~w_mis;
  assign w_ack     = w_req & mem.memAck;

  // Counter advances on every stalled cycle, including the first one in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req & ~mem.memAck) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_abort = w_req & ~mem.memAck & (r_cnt == CW'(TIMEOUT - 1));
        if (~w_req | mem.memAck | w_abort) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_stall = w_req & ~mem.memAck & ~w_abort;
    if (w_stall) w_cnt_nxt = r_cnt + CW'(1);
  end

  assign w_lane  = ALUResultM[LB-1:0];
  assign w_hlane = w_lane & ~LB'(1);
  assign w_d     = writeDataM + WIDTH'(plusOneM);
  assign w_rb    = 8'(mem.memRData >> {w_lane, 3'b000});
  assign w_rh    = 16'(mem.memRData >> {w_hlane, 3'b000});

  always_comb begin
    w_wdat = w_d;
    w_be   = '1;
    w_ld   = mem.memRData;
    if (w_is_byte) begin
      w_wdat = {NB{w_d[7:0]}};
      w_be   = NB'(1) << w_lane;
      w_ld   = {{(WIDTH-8){signedM & w_rb[7]}}, w_rb};
    end else if (w_is_half) begin
      w_wdat = {(NB/2){w_d[15:0]}};
      w_be   = NB'(3) << w_hlane;
      w_ld   = {{(WIDTH-16){signedM & w_rh[15]}}, w_rh};
    end
  end

  assign mem.memReq   = w_req;
  assign mem.memWe    = w_req & memWriteM;
  assign mem.memAddr  = ALUResultM;
  assign mem.memWData = w_wdat;
  assign mem.memBE    = w_be;
  assign stallM       = w_stall;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_validW     <= 1'b0;
      r_memToRegW  <= 1'b0;
      r_regWriteW  <= 1'b0;
      r_ALUResultW <= '0;
      r_readDataW  <= '0;
      r_WA3W       <= '0;
      r_err        <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_mis)   r_err[0] <= 1'b1;
      if (w_abort) r_err[1] <= 1'b1;
      if (w_stall) begin
        r_validW    <= 1'b0;
        r_regWriteW <= 1'b0;
        r_memToRegW <= 1'b0;
      end else begin
        r_ALUResultW <= ALUResultM;
        r_WA3W       <= WA3M;
        r_validW     <= validM & ~flushM;
        r_regWriteW  <= regWriteM & ~flushM & ~w_mis & ~w_abort;
        r_memToRegW  <= memToRegM & ~flushM & ~w_abort;
        if (w_ack & ~memWriteM) r_readDataW <= w_ld;
      end
    end
  end

  assign validW     = r_validW;
  assign memToRegW  = r_memToRegW;
  assign regWriteW  = r_regWriteW;
  assign ALUResultW = r_ALUResultW;
  assign readDataW  = r_readDataW;
  assign WA3W       = r_WA3W;
  assign errFlags   = r_err;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a behavioural reference model.
module tb_mem_stage_hs;
  localparam int WIDTH   = 32;
  localparam int REGW    = 32;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              resetN;
  logic              validM, memReadM, memWriteM, signedM, plusOneM;
  logic              memToRegM, regWriteM, flushM;
  logic [1:0]        sizeM;
  logic [WIDTH-1:0]  ALUResultM, writeDataM;
  logic [REGW-1:0]   WA3M;
  logic              stallM, validW, memToRegW, regWriteW;
  logic [WIDTH-1:0]  ALUResultW, readDataW;
  logic [REGW-1:0]   WA3W;
  logic [1:0]        errFlags;

  mem_stage_hs_if #(.WIDTH(WIDTH)) mif ();

  mem_stage_hs #(.WIDTH(WIDTH), .REGW(REGW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetN(resetN),
    .validM(validM), .memReadM(memReadM), .memWriteM(memWriteM),
    .sizeM(sizeM), .signedM(signedM), .plusOneM(plusOneM),
    .ALUResultM(ALUResultM), .writeDataM(writeDataM), .WA3M(WA3M),
    .memToRegM(memToRegM), .regWriteM(regWriteM), .flushM(flushM),
    .mem(mif), .stallM(stallM),
    .validW(validW), .memToRegW(memToRegW), .regWriteW(regWriteW),
    .ALUResultW(ALUResultW), .readDataW(readDataW), .WA3W(WA3W),
    .errFlags(errFlags)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        vld, rd, wr;
    logic [1:0]  sz;
    logic        sg, p1, fl, ack;
    logic [31:0] addr, wd, rdata;
    logic        rw;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdat;
    logic        e_vw, e_rw;
    logic [31:0] e_rdw;
    logic [1:0]  e_err;
  } vec_t;

  vec_t tbl[12];

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b10:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input int off, input int nb);
    return 4'(((1 << nb) - 1) << ((off / nb) * nb));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int nb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = r | (((d >> (8 * (i % nb))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input int nb, input logic sg);
    longint v;
    if (nb == 4) return rd;
    v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
    if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  task automatic idle();
    validM = 0; memReadM = 0; memWriteM = 0; sizeM = 2'b00; signedM = 0; plusOneM = 0;
    ALUResultM = '0; writeDataM = '0; WA3M = '0; memToRegM = 0; regWriteM = 0; flushM = 0;
    mif.memRData = '0; mif.memAck = 0;
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                    input logic p1, input logic [31:0] addr, input logic [31:0] wd);
    validM = 1; memReadM = rd; memWriteM = wr; sizeM = sz; signedM = sg; plusOneM = p1;
    ALUResultM = addr; writeDataM = wd; memToRegM = rd & ~wr; regWriteM = rd & ~wr;
    WA3M = REGW'(7); flushM = 0;
  endtask

  task automatic do_reset();
    resetN = 0;
    idle();
    edge1();
    edge1();
    resetN = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int          cnt, nb, off, delay, waited;
    logic        memop, mis, req, abort, stall, prev_stall;
    logic [31:0] tmp, m_alu, m_rd;
    logic [REGW-1:0] m_wa;
    logic        m_v, m_rw, m_mr;
    logic [1:0]  m_err;

    //            vld rd wr sz     sg p1 fl ack addr          wd            rdata         rw  req be       wdat          vw rw rdw           err
    tbl[0]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0000_1234, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        1, 1, 32'h0,        2'b00};
    tbl[1]  = '{1, 1, 0, 2'b10, 1, 0, 0, 1, 32'h0000_0103, 32'h0,        32'h8000_0000, 1, 1, 4'b1000, 32'h0,       1, 1, 32'hFFFF_FF80, 2'b00};
    tbl[2]  = '{1, 1, 0, 2'b01, 0, 0, 0, 1, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 1, 1, 4'b1100, 32'h0,       1, 1, 32'h0000_BEEF, 2'b00};
    tbl[3]  = '{1, 1, 0, 2'b01, 1, 0, 0, 1, 32'h0000_0100, 32'h0,        32'h0000_8001, 1, 1, 4'b0011, 32'h0,       1, 1, 32'hFFFF_8001, 2'b00};
    tbl[4]  = '{1, 1, 0, 2'b11, 1, 0, 0, 1, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 1, 1, 4'b1111, 32'h0,       1, 1, 32'hCAFE_F00D, 2'b00};
    tbl[5]  = '{1, 0, 1, 2'b10, 0, 1, 0, 1, 32'h0000_0101, 32'h0000_00AB, 32'h0,       0, 1, 4'b0010, 32'hACAC_ACAC, 1, 0, 32'hCAFE_F00D, 2'b00};
    tbl[6]  = '{1, 0, 1, 2'b01, 0, 0, 0, 1, 32'h0000_0106, 32'h0000_1234, 32'h0,       0, 1, 4'b1100, 32'h1234_1234, 1, 0, 32'hCAFE_F00D, 2'b00};
    tbl[7]  = '{1, 1, 1, 2'b00, 0, 1, 0, 1, 32'h0000_0108, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 1, 4'b1111, 32'h0,     1, 0, 32'hCAFE_F00D, 2'b00};
    tbl[8]  = '{1, 1, 0, 2'b00, 0, 0, 1, 1, 32'h0000_010C, 32'h0,        32'h1111_1111, 1, 0, 4'b0000, 32'h0,       0, 0, 32'hCAFE_F00D, 2'b00};
    tbl[9]  = '{1, 1, 0, 2'b10, 0, 0, 0, 1, 32'h0000_0101, 32'h0,        32'h0000_8F00, 1, 1, 4'b0010, 32'h0,       1, 1, 32'h0000_008F, 2'b00};
    tbl[10] = '{1, 1, 0, 2'b01, 0, 0, 0, 1, 32'h0000_0101, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        1, 0, 32'h0000_008F, 2'b01};
    tbl[11] = '{1, 0, 1, 2'b00, 0, 0, 0, 0, 32'h0000_0102, 32'h0000_0005, 32'h0,       0, 0, 4'b0000, 32'h0,        1, 0, 32'h0000_008F, 2'b01};

    do_reset();
    chk("rst_validW", validW, 0);
    chk("rst_regWriteW", regWriteW, 0);
    chk("rst_memToRegW", memToRegW, 0);
    chk("rst_ALUResultW", ALUResultW, 0);
    chk("rst_readDataW", readDataW, 0);
    chk("rst_WA3W", WA3W, 0);
    chk("rst_errFlags", errFlags, 0);
    mid();
    chk("rst_memReq", mif.memReq, 0);
    chk("rst_stallM", stallM, 0);
    edge1();

    for (int i = 0; i < 12; i++) begin
      validM = tbl[i].vld; memReadM = tbl[i].rd; memWriteM = tbl[i].wr; sizeM = tbl[i].sz;
      signedM = tbl[i].sg; plusOneM = tbl[i].p1; flushM = tbl[i].fl;
      ALUResultM = tbl[i].addr; writeDataM = tbl[i].wd; regWriteM = tbl[i].rw;
      memToRegM = tbl[i].rd & ~tbl[i].wr; WA3M = REGW'(i + 3);
      mif.memAck = tbl[i].ack; mif.memRData = tbl[i].rdata;
      mid();
      chk($sformatf("vec%0d_memReq", i), mif.memReq, tbl[i].e_req);
      chk($sformatf("vec%0d_stallM", i), stallM, 0);
      if (tbl[i].e_req) begin
        chk($sformatf("vec%0d_memBE", i), mif.memBE, tbl[i].e_be);
        chk($sformatf("vec%0d_memWe", i), mif.memWe, tbl[i].wr);
        chk($sformatf("vec%0d_memAddr", i), mif.memAddr, tbl[i].addr);
        if (tbl[i].wr) chk($sformatf("vec%0d_memWData", i), mif.memWData, tbl[i].e_wdat);
      end
      edge1();
      chk($sformatf("vec%0d_validW", i), validW, tbl[i].e_vw);
      chk($sformatf("vec%0d_regWriteW", i), regWriteW, tbl[i].e_rw);
      chk($sformatf("vec%0d_readDataW", i), readDataW, tbl[i].e_rdw);
      chk($sformatf("vec%0d_errFlags", i), errFlags, tbl[i].e_err);
      if (tbl[i].e_vw) begin
        chk($sformatf("vec%0d_ALUResultW", i), ALUResultW, tbl[i].addr);
        chk($sformatf("vec%0d_WA3W", i), WA3W, i + 3);
      end
    end
    idle();

    // Word store with ack on the fourth cycle.
    op(0, 1, 2'b00, 0, 1, 32'h100, 32'h7);
    mif.memAck = 0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk($sformatf("st_wait%0d_memReq", k), mif.memReq, 1);
      chk($sformatf("st_wait%0d_stallM", k), stallM, 1);
      chk($sformatf("st_wait%0d_memWe", k), mif.memWe, 1);
      chk($sformatf("st_wait%0d_memWData", k), mif.memWData, 32'h8);
      chk($sformatf("st_wait%0d_memBE", k), mif.memBE, 4'b1111);
      edge1();
      chk($sformatf("st_wait%0d_bubble", k), validW, 0);
    end
    mif.memAck = 1;
    mid();
    chk("st_ack_stallM", stallM, 0);
    edge1();
    chk("st_commit_validW", validW, 1);
    chk("st_commit_ALUResultW", ALUResultW, 32'h100);
    idle();

    // Load that is never acknowledged.
    do_reset();
    op(1, 0, 2'b00, 0, 0, 32'h200, 32'h0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      mid();
      if (!stallM) break;
      cnt++;
      edge1();
    end
    chk("to_stall_cycles", cnt, TIMEOUT - 1);
    edge1();
    chk("to_errFlags", errFlags, 2'b10);
    chk("to_regWriteW", regWriteW, 0);
    chk("to_memToRegW", memToRegW, 0);
    chk("to_validW", validW, 1);
    op(1, 0, 2'b00, 0, 0, 32'h204, 32'h0);
    mif.memAck = 1; mif.memRData = 32'h55;
    mid();
    chk("to_next_stallM", stallM, 0);
    edge1();
    chk("to_next_readDataW", readDataW, 32'h55);
    chk("to_next_regWriteW", regWriteW, 1);

    // Flush while waiting; the ack in the flush cycle must be ignored.
    op(1, 0, 2'b00, 0, 0, 32'h300, 32'h0);
    mif.memAck = 0; mif.memRData = 32'h99;
    edge1();
    edge1();
    flushM = 1; mif.memAck = 1;
    mid();
    chk("fl_memReq", mif.memReq, 0);
    chk("fl_stallM", stallM, 0);
    edge1();
    chk("fl_validW", validW, 0);
    chk("fl_regWriteW", regWriteW, 0);
    chk("fl_errFlags", errFlags, 2'b10);
    chk("fl_readDataW", readDataW, 32'h55);
    idle();
    mid();
    chk("fl_after_memReq", mif.memReq, 0);
    edge1();

    // Reset while waiting clears everything and abandons the access.
    op(1, 0, 2'b00, 0, 0, 32'h400, 32'h0);
    mif.memAck = 0;
    edge1();
    edge1();
    resetN = 0; mif.memAck = 1; mif.memRData = 32'h77;
    edge1();
    chk("rw_errFlags", errFlags, 2'b00);
    chk("rw_validW", validW, 0);
    chk("rw_readDataW", readDataW, 0);
    chk("rw_ALUResultW", ALUResultW, 0);
    resetN = 1;
    idle();
    mid();
    chk("rw_memReq", mif.memReq, 0);
    chk("rw_stallM", stallM, 0);
    edge1();

    // Randomized traffic against the reference model.
    do_reset();
    m_alu = '0; m_rd = '0; m_wa = '0; m_v = 0; m_rw = 0; m_mr = 0; m_err = 2'b00;
    waited = 0; prev_stall = 0; delay = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!prev_stall) begin
        validM = (($urandom % 10) != 0);
        memReadM = 1'($urandom % 2); memWriteM = 1'($urandom % 2);
        sizeM = 2'($urandom % 4); signedM = 1'($urandom % 2); plusOneM = 1'($urandom % 2);
        nb = nbytes(sizeM);
        tmp = $urandom;
        off = int'($urandom % 4);
        if (($urandom % 4) != 0) off = off - (off % nb);
        tmp[1:0] = 2'(off);
        ALUResultM = tmp;
        writeDataM = $urandom; WA3M = REGW'($urandom);
        regWriteM = validM & 1'($urandom % 2);
        memToRegM = validM & memReadM & ~memWriteM;
        case ($urandom % 8)
          0, 1, 2: delay = 0;
          3, 4:    delay = 1;
          5:       delay = 3;
          6:       delay = 6;
          default: delay = TIMEOUT + 4;
        endcase
      end
      flushM = (($urandom % 25) == 0);
      mif.memAck = (waited >= delay) || (($urandom % 6) == 0);
      mif.memRData = $urandom;

      nb    = nbytes(sizeM);
      off   = int'(ALUResultM % 4);
      memop = validM && (memReadM || memWriteM) && !flushM;
      mis   = memop && ((off % nb) != 0);
      req   = memop && !mis;
      abort = req && !mif.memAck && (waited == TIMEOUT - 1);
      stall = req && !mif.memAck && !abort;

      mid();
      chk("rnd_memReq", mif.memReq, req);
      chk("rnd_stallM", stallM, stall);
      if (req) begin
        chk("rnd_memWe", mif.memWe, memWriteM);
        chk("rnd_memAddr", mif.memAddr, ALUResultM);
        chk("rnd_memBE", mif.memBE, ref_be(off, nb));
        if (memWriteM) chk("rnd_memWData", mif.memWData, ref_wdata(writeDataM + 32'(plusOneM), nb));
      end

      if (stall) begin
        m_v = 0; m_rw = 0; m_mr = 0;
      end else begin
        m_alu = ALUResultM; m_wa = WA3M;
        m_v  = validM && !flushM;
        m_rw = regWriteM && !flushM && !mis && !abort;
        m_mr = memToRegM && !flushM && !abort;
        if (req && mif.memAck && !memWriteM) m_rd = ref_load(mif.memRData, off, nb, signedM);
      end
      if (mis)   m_err[0] = 1'b1;
      if (abort) m_err[1] = 1'b1;
      waited = stall ? waited + 1 : 0;
      prev_stall = stall;

      edge1();
      chk("rnd_validW", validW, m_v);
      chk("rnd_regWriteW", regWriteW, m_rw);
      chk("rnd_memToRegW", memToRegW, m_mr);
      chk("rnd_ALUResultW", ALUResultW, m_alu);
      chk("rnd_WA3W", WA3W, m_wa);
      chk("rnd_readDataW", readDataW, m_rd);
      chk("rnd_errFlags", errFlags, m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
